// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: marker byte, host command opcodes,
// per-latch dump sizes and the frame serializer state encoding.
package debug_pkg;

  // Marker sent after a frame to tell the host the core is ready again
  localparam logic [7:0] READY_CHAR = 8'h52;

  // Host command opcodes
  localparam logic [7:0] CMD_DUMP_IF_ID  = 8'h02;
  localparam logic [7:0] CMD_DUMP_ID_EX  = 8'h03;
  localparam logic [7:0] CMD_DUMP_EX_MEM = 8'h04;
  localparam logic [7:0] CMD_DUMP_MEM_WB = 8'h05;
  localparam logic [7:0] CMD_LOAD        = 8'h07;
  localparam logic [7:0] CMD_CONTINUOUS  = 8'h08;
  localparam logic [7:0] CMD_STEP        = 8'h0A;
  localparam logic [7:0] CMD_RUN         = 8'h0D;
  localparam logic [7:0] CMD_STEP_MODE   = 8'h11;

  // Bytes per pipeline latch dump
  localparam int unsigned BYTES_IF_ID  = 4;
  localparam int unsigned BYTES_ID_EX  = 17;
  localparam int unsigned BYTES_EX_MEM = 10;
  localparam int unsigned BYTES_MEM_WB = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StMark,
    StWaitM,
    StFin
  } tx_state_t;

endpackage

// File: rtl/debug_frame_tx.sv
// Debug response serializer: snapshots a frame and streams it LSB byte first
// into an external 8N1 uart_tx, optionally followed by the ready marker.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 136,
  parameter int unsigned MAX_BYTES  = (FRAME_BITS + 7) / 8,
  parameter int unsigned CNT_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic [CNT_W-1:0]      i_num_bytes,
  input  logic                  i_send_ready,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_byte_idx
);

  localparam int unsigned ShiftW = MAX_BYTES * 8;

  tx_state_t          state_q, state_d;
  logic [ShiftW-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   idx_inc;
  logic [CNT_W-1:0]   num_clamp;

  assign idx_inc   = idx_q + CNT_W'(1);
  // Oversized requests are clamped so nothing past the shift register is sent
  assign num_clamp = (i_num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : i_num_bytes;

  assign o_busy     = (state_q != StIdle);
  assign o_byte_idx = idx_q;

  // State, shift register and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and uart handshake outputs
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    num_d      = num_q;
    ready_d    = ready_q;
    o_tx_start = 1'b0;
    o_tx_data  = 8'h00;
    o_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          shift_d = ShiftW'(i_frame);
          idx_d   = '0;
          num_d   = num_clamp;
          ready_d = i_send_ready;
          if (num_clamp != '0) begin
            state_d = StSend;
          end else if (i_send_ready) begin
            state_d = StMark;
          end else begin
            state_d = StFin;
          end
        end
      end
      StSend: begin
        o_tx_start = 1'b1;
        o_tx_data  = shift_q[7:0];
        state_d    = StWait;
      end
      StWait: begin
        o_tx_data = shift_q[7:0];
        if (i_tx_done) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_inc;
          if (idx_inc < num_q) begin
            state_d = StSend;
          end else if (ready_q) begin
            state_d = StMark;
          end else begin
            state_d = StFin;
          end
        end
      end
      StMark: begin
        o_tx_start = 1'b1;
        o_tx_data  = READY_CHAR;
        state_d    = StWaitM;
      end
      StWaitM: begin
        o_tx_data = READY_CHAR;
        if (i_tx_done) begin
          state_d = StFin;
        end
      end
      StFin: begin
        o_done  = 1'b1;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: a uart_tx model answers each o_tx_start with
// i_tx_done 20 cycles later; bytes are scored against an expected queue.
module tb_debug_frame_tx;

  localparam int FB = 136;
  localparam int MB = 17;
  localparam int CW = 5;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [FB-1:0] i_frame;
  logic [CW-1:0] i_num_bytes;
  logic          i_send_ready;
  logic          i_tx_done;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_byte_idx;

  logic model_done;
  logic spur_done;
  assign i_tx_done = model_done | spur_done;

  debug_frame_tx dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_frame      (i_frame),
    .i_num_bytes  (i_num_bytes),
    .i_send_ready (i_send_ready),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_byte_idx   (o_byte_idx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int cd = 0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // uart_tx model and byte scoreboard, sampled on the falling edge
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      cd         = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          model_done = 1'b1;
          check("data_hold", {24'h0, o_tx_data}, {24'h0, held});
        end
      end
      if (o_done) done_cnt++;
      if (o_tx_start) begin
        start_cnt++;
        check("one_outstanding", cd, 0);
        check("q_has_exp", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
        held = o_tx_data;
        cd   = 20;
      end
    end
  end

  task automatic send_frame(input logic [FB-1:0] frame, input int nn, input bit sr);
    int eff;
    eff = (nn > MB) ? MB : nn;
    @(negedge i_clk);
    for (int i = 0; i < eff; i++) exp_q.push_back(frame[8*i +: 8]);
    if (sr) exp_q.push_back(8'h52);
    i_frame      = frame;
    i_num_bytes  = CW'(nn);
    i_send_ready = sr;
    i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    check("busy_n1", o_busy, 1);
    check("start_n1", o_tx_start, (eff > 0 || sr) ? 1 : 0);
    check("done_n1", o_done, (eff == 0 && !sr) ? 1 : 0);
    @(negedge i_clk);
    i_start = 1'b0;
    i_frame = ~frame;  // capture must already have happened
  endtask

  task automatic wait_done(input int budget);
    int c;
    bit seen;
    c    = 0;
    seen = 0;
    while (!seen && c < budget) begin
      if (o_done) seen = 1;
      else begin
        @(negedge i_clk);
        c++;
      end
    end
    check("done_seen", seen, 1);
    @(negedge i_clk);
    check("busy_after", o_busy, 0);
    check("q_empty", exp_q.size(), 0);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int c;
    c = 0;
    while (!(o_busy && o_byte_idx == CW'(idx)) && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    check("idx_reached", o_byte_idx, idx);
  endtask

  logic [FB-1:0] f;
  int d0, s0;

  initial begin
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_frame      = '0;
    i_num_bytes  = '0;
    i_send_ready = 1'b0;
    spur_done    = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_tx_start, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_done", o_done, 0);
    check("rst_idx", o_byte_idx, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // 1: IF/ID word plus marker
    d0 = done_cnt;
    f  = '0;
    f[31:0] = 32'h0C010003;
    send_frame(f, 4, 1'b1);
    wait_done(400);
    repeat (30) @(negedge i_clk);
    check("t1_one_done", done_cnt, d0 + 1);

    // 2: full ID/EX latch, only bit 128 set, no marker
    f = '0;
    f[128] = 1'b1;
    send_frame(f, 17, 1'b0);
    wait_done(1000);

    // 3: empty frames
    send_frame('0, 0, 1'b1);
    wait_done(100);
    s0 = start_cnt;
    send_frame('0, 0, 1'b0);
    wait_done(20);
    check("t3_no_start", start_cnt, s0);

    // 4: i_start during byte 2 is ignored
    d0 = done_cnt;
    f  = '0;
    for (int i = 0; i < 10; i++) f[8*i +: 8] = 8'(8'h10 + i);
    send_frame(f, 10, 1'b1);
    wait_idx(2, 200);
    i_frame     = {FB{1'b1}};
    i_num_bytes = CW'(3);
    i_start     = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(600);
    repeat (40) @(negedge i_clk);
    check("t4_one_done", done_cnt, d0 + 1);

    // 5: reset during byte 3 abandons the frame
    d0 = done_cnt;
    f  = '0;
    for (int i = 0; i < 10; i++) f[8*i +: 8] = 8'(8'hA0 + i);
    send_frame(f, 10, 1'b1);
    wait_idx(3, 200);
    i_rst_n = 1'b0;
    #1;
    check("t5_busy", o_busy, 0);
    check("t5_start", o_tx_start, 0);
    check("t5_data", o_tx_data, 0);
    check("t5_done", o_done, 0);
    check("t5_idx", o_byte_idx, 0);
    exp_q.delete();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("t5_no_done", done_cnt, d0);
    f = '0;
    for (int i = 0; i < 9; i++) f[8*i +: 8] = 8'(8'h30 + 3 * i);
    send_frame(f, 9, 1'b0);
    wait_done(600);

    // 6: oversized count clamps to 17 bytes
    f = '0;
    for (int i = 0; i < MB; i++) f[8*i +: 8] = 8'(8'hC0 + i);
    send_frame(f, 31, 1'b0);
    wait_done(1000);
    repeat (30) @(negedge i_clk);
    s0 = start_cnt;
    spur_done = 1'b1;
    @(negedge i_clk);
    spur_done = 1'b0;
    repeat (5) @(negedge i_clk);
    check("t6_spur_start", start_cnt, s0);
    check("t6_spur_busy", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
